relu_stream_ctrl: RTL
=====================

# relu_stream_ctrl

Sequencer for the ReLU stage of the CNN pipeline. On a start command it reads a feature map from the convolution result buffer, one pixel per address. It clamps each signed pixel through ReLU, or passes it through when bypassed, and streams the results to the next layer over a valid/ready interface with a last flag. It throttles buffer reads so output backpressure never loses data, and it reports how many pixels were clamped.

## Interface
- DATA_W, 16, pixel width, two's complement
- ADDR_W, 12, buffer address width; also max frame length 2^ADDR_W−1
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  frame command; accepted only in IDLE
- num_pix  in  ADDR_W  pixels in frame; sampled when start is accepted
- relu_en  in  1  1 = clamp negatives to 0, 0 = bypass; sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final output handshake
- rd_en  out  1  buffer read strobe
- rd_addr  out  ADDR_W  buffer read address
- rd_data  in  DATA_W  buffer data, valid exactly 1 cycle after rd_en
- out_data  out  DATA_W  result pixel
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_last  out  1  qualifies the final pixel of the frame
- neg_count  out  ADDR_W  count of pixels with sign bit set in the current/last frame

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE → RUN: start=1. Latch num_pix and relu_en, and clear neg_count, rd_addr, the issued count and the emitted count.
- IDLE → DONE: start=1 and num_pix=0. No reads, no output beats.
- RUN: issue reads at addresses 0..num_pix−1 in order. When the last read is issued, go to FLUSH.
- FLUSH: no reads. Go to DONE on the handshake of the beat with out_last.
- DONE: done=1 for one cycle, then go to IDLE.
- start is ignored outside IDLE.
- Output path:
  - 2-entry FIFO plus 1 in-flight read slot.
  - Issue rule: rd_en = RUN && (occupancy + inflight − pop) < 2, where pop = out_valid && out_ready in that cycle. This guarantees no overflow and sustains 1 pixel/cycle while out_ready stays high.
- Clamp: applied when rd_data is written into the FIFO.
  - relu_en=1: a pixel with bit DATA_W−1 set becomes all zeros; otherwise it is unchanged.
  - relu_en=0: the pixel is unchanged.
- neg_count increments for each returned pixel with its sign bit set, whatever relu_en is. It saturates at all-ones and holds its value after done until the next accepted start.
- out_last travels with the FIFO entry; it is set on the pixel read from address num_pix−1.
- out_data and out_valid must stay stable while out_valid && !out_ready.

## Timing
- Reset values:
  - Reset applies in every state. A read already in flight is discarded.
  - State is IDLE.
  - busy, done, rd_en, out_valid and out_last are 0.
  - rd_addr, out_data and neg_count are 0.
  - The FIFO is empty.
- Start accepted in cycle 0 → busy=1 and rd_en=1 with rd_addr=0 in cycle 1 → rd_data in cycle 2 → out_valid=1 in cycle 3. Fixed latency from start to first beat is 3 cycles.
- With out_ready held high, beats occur in consecutive cycles and the last beat is in cycle num_pix+2. done=1 in cycle num_pix+3 with busy=0 in that same cycle. IDLE from cycle num_pix+4.
- If num_pix=0, done=1 in cycle 1 and busy stays 0.
- With out_ready low, at most 2 pixels are buffered and rd_en stays low until a pop frees space. When out_ready returns, output restarts in the same cycle and reads restart in the same cycle.
- A push and a pop in the same cycle on a full FIFO is legal, and occupancy is unchanged.

## Structure
- The shared package cnn_pkg holds the DATA_W and ADDR_W defaults and the state enum (IDLE, RUN, FLUSH, DONE).
- One sub-module, relu_skid_fifo: a 2-entry FIFO of {last, data} with push, pop, occupancy, full and empty.
- The counters, the issue logic, the clamp and the FSM stay in relu_stream_ctrl.

## Test plan
- num_pix=4, rd_data for addresses 0..3 = 0x0005, 0xFFFE, 0x8000, 0x7FFF, relu_en=1, out_ready=1 → out_data 0x0005, 0x0000, 0x0000, 0x7FFF in cycles 3–6. out_last only on 0x7FFF. done in cycle 7. neg_count=2.
- Same frame with relu_en=0 → out_data 0x0005, 0xFFFE, 0x8000, 0x7FFF. neg_count=2.
- num_pix=8 with out_ready toggling 1,0,0,1 repeating → all 8 pixels arrive in order with none dropped or duplicated. Occupancy is never above 2. rd_en is low whenever the FIFO plus in-flight slot is full.
- num_pix=0 → done=1 in cycle 1, no rd_en, no out_valid, neg_count=0.
- start pulsed again during RUN with num_pix=3 → ignored, and the original frame length completes.
- rst_n=0 for one cycle in the middle of a frame with 2 entries buffered → next cycle: IDLE, out_valid=0, FIFO empty, neg_count=0. A new start then produces a clean frame.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN pipeline stages: default widths and the
// sequencer state encoding.
package cnn_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } relu_state_e;

endpackage

// File: rtl/relu_skid_fifo.sv
// Two-entry FIFO holding {last, data} result beats between the buffer read
// return and the downstream valid/ready port.
module relu_skid_fifo
  import cnn_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       occupancy,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only taken when the same cycle pops.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occupancy <= occupancy + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (occupancy == 2'd2);
  assign empty = (occupancy == 2'd0);

endmodule

// File: rtl/relu_stream_ctrl.sv
// ReLU stage sequencer: reads a frame from the conv result buffer, clamps or
// bypasses each pixel and streams it out with backpressure-safe read throttling.
module relu_stream_ctrl
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_pix,
  input  logic              relu_en,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [ADDR_W-1:0] neg_count
);

  relu_state_e       state;
  logic [ADDR_W-1:0] num_q;
  logic              relu_q;
  logic              inflight;
  logic              inflight_last;
  logic              last_issue;
  logic              pop;
  logic [DATA_W-1:0] pix;
  logic [DATA_W:0]   head;
  logic [1:0]        occupancy;
  logic              full;
  logic              empty;
  logic [2:0]        slots;

  assign out_valid = !empty;
  assign out_data  = head[DATA_W-1:0];
  assign out_last  = head[DATA_W];
  assign pop       = out_valid && out_ready;

  // Buffered plus in-flight pixels that remain after this cycle's pop; a new
  // read is only issued while that leaves room in the two FIFO entries.
  assign slots      = ({1'b0, occupancy} + {2'b00, inflight}) - {2'b00, pop};
  assign rd_en      = (state == RUN) && !(full && !pop) && (slots < 3'd2);
  assign last_issue = (rd_addr == num_q - ADDR_W'(1));

  assign pix = (relu_q && rd_data[DATA_W-1]) ? '0 : rd_data;

  relu_skid_fifo #(
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data ({inflight_last, pix}),
    .pop       (pop),
    .head      (head),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      rd_addr       <= '0;
      num_q         <= '0;
      relu_q        <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      neg_count     <= '0;
    end else begin
      inflight      <= rd_en;
      inflight_last <= rd_en && last_issue;
      if (rd_en) begin
        rd_addr <= rd_addr + ADDR_W'(1);
      end
      // Negatives are counted on return regardless of the clamp setting.
      if (inflight && rd_data[DATA_W-1] && (neg_count != '1)) begin
        neg_count <= neg_count + ADDR_W'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            num_q     <= num_pix;
            relu_q    <= relu_en;
            neg_count <= '0;
            rd_addr   <= '0;
            if (num_pix == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (rd_en && last_issue) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (pop && out_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
